// File: rtl/hbm_rd_arbiter_pkg.sv
// hbm_rd_arbiter_pkg
// Shared types and constants for the HBM read-port arbiter.
//   arb_state_t : arbiter FSM state encoding (idle / address / data phase)
//   AXI_LEN_W   : AXI4 burst length field width
//   BEAT_W      : beat counter width (one extra bit so an over-long burst
//                 does not alias back onto a legal beat index)
package hbm_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam int AXI_LEN_W = 8;
    localparam int BEAT_W    = 9;

    // Widen an AXI length field to beat-counter width for comparison.
    function automatic logic [BEAT_W-1:0] len_ext(input logic [AXI_LEN_W-1:0] len);
        return {1'b0, len};
    endfunction

endpackage

// File: rtl/hbm_rd_arbiter_rr_pick.sv
// rr_pick
// Combinational rotate-priority picker: grants the first asserted request
// at or after index ptr, wrapping modulo NUM_REQ.
//   req : request vector
//   ptr : index that currently has highest priority
//   gnt : one-hot pick, all-zero when no request is asserted
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/hbm_rd_arbiter.sv
// hbm_rd_arbiter
// Round-robin arbiter letting NUM_REQ per-column HBM read masters share one
// AXI4 read port. One burst outstanding at a time; the grant is held from the
// AR pick until the R beat carrying rlast. Burst length is checked against the
// latched arlen and a mismatch raises a one-cycle err_len pulse.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   s_arvalid/s_arready/s_araddr/s_arlen : per-requester AR channels (packed)
//   s_rvalid/s_rready                 : per-requester R handshake
//   s_rdata/s_rlast                   : R payload broadcast to all requesters
//   m_ar*, m_r*                       : shared master AR/R channels
//   grant                             : one-hot current owner, zero when idle
//   err_len                           : burst-length mismatch pulse
module hbm_rd_arbiter
    import hbm_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            s_arvalid,
    output logic [NUM_REQ-1:0]            s_arready,
    input  logic [NUM_REQ*ADDR_W-1:0]     s_araddr,
    input  logic [NUM_REQ*AXI_LEN_W-1:0]  s_arlen,
    output logic [NUM_REQ-1:0]            s_rvalid,
    input  logic [NUM_REQ-1:0]            s_rready,
    output logic [DATA_W-1:0]             s_rdata,
    output logic                          s_rlast,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    output logic [ADDR_W-1:0]             m_araddr,
    output logic [AXI_LEN_W-1:0]          m_arlen,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    input  logic [DATA_W-1:0]             m_rdata,
    input  logic                          m_rlast,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          err_len
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t           state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IDX_W-1:0]     gidx_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [AXI_LEN_W-1:0] len_q;
    logic [BEAT_W-1:0]    beat_q;
    logic                 err_q;

    logic [NUM_REQ-1:0]   pick;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     next_ptr;
    logic                 r_hs;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req (s_arvalid),
        .ptr (rr_ptr_q),
        .gnt (pick)
    );

    // Binary index of the one-hot pick, used for slicing the packed buses.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end else begin
                pick_idx = pick_idx;
            end
        end
    end

    // Priority moves to the requester after the one that just finished.
    always_comb begin
        if (gidx_q == IDX_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = gidx_q + IDX_W'(1);
        end
    end

    assign r_hs = (state_q == ARB_DATA) && m_rvalid && m_rready;

    // Arbiter FSM: pick, address phase, data phase with length checking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (|s_arvalid) begin
                        grant_q <= pick;
                        gidx_q  <= pick_idx;
                        len_q   <= s_arlen[int'(pick_idx)*AXI_LEN_W +: AXI_LEN_W];
                        state_q <= ARB_ADDR;
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_ADDR: begin
                    // A requester withdrawing arvalid forfeits the grant
                    // without consuming its round-robin turn.
                    if (!s_arvalid[gidx_q]) begin
                        grant_q <= '0;
                        state_q <= ARB_IDLE;
                    end else if (m_arready) begin
                        beat_q  <= '0;
                        state_q <= ARB_DATA;
                    end else begin
                        state_q <= ARB_ADDR;
                    end
                end
                ARB_DATA: begin
                    if (r_hs) begin
                        beat_q <= beat_q + BEAT_W'(1);
                        if (m_rlast) begin
                            err_q    <= (beat_q != len_ext(len_q));
                            rr_ptr_q <= next_ptr;
                            grant_q  <= '0;
                            state_q  <= ARB_IDLE;
                        end else begin
                            // Expected last beat came without rlast; keep
                            // draining until the slave terminates the burst.
                            err_q <= (beat_q == len_ext(len_q));
                        end
                    end else begin
                        state_q <= ARB_DATA;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    // Combinational AR/R steering to and from the granted requester.
    always_comb begin
        s_arready = '0;
        s_rvalid  = '0;
        s_rdata   = '0;
        s_rlast   = 1'b0;
        m_arvalid = 1'b0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_rready  = 1'b0;
        case (state_q)
            ARB_ADDR: begin
                m_arvalid         = s_arvalid[gidx_q];
                m_araddr          = s_araddr[int'(gidx_q)*ADDR_W +: ADDR_W];
                m_arlen           = s_arlen[int'(gidx_q)*AXI_LEN_W +: AXI_LEN_W];
                s_arready[gidx_q] = m_arready;
            end
            ARB_DATA: begin
                s_rvalid[gidx_q] = m_rvalid;
                m_rready         = s_rready[gidx_q];
                s_rdata          = m_rdata;
                s_rlast          = m_rlast;
            end
            default: begin
                m_arvalid = 1'b0;
            end
        endcase
    end

    assign grant   = grant_q;
    assign err_len = err_q;

endmodule

// File: tb/tb_hbm_rd_arbiter.sv
// tb_hbm_rd_arbiter
// Self-checking bench for hbm_rd_arbiter: directed scenarios (single request,
// round-robin order, backpressure, length error, AR abort, reset mid-burst)
// followed by randomized rounds. The bench plays the requesters and the HBM
// slave; a transaction-level model tracks pending requests and the priority
// pointer and predicts grant, addresses, beat counts and error pulses.
module tb_hbm_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      s_arvalid, s_arready, s_rvalid, s_rready, grant;
    logic [N*AW-1:0]   s_araddr;
    logic [N*8-1:0]    s_arlen;
    logic [DW-1:0]     s_rdata, m_rdata;
    logic              s_rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, err_len;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          ptr;
    bit          pend  [N];
    logic [63:0] paddr [N];
    int          plen  [N];

    hbm_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .grant(grant), .err_len(err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // First pending requester at or after the priority pointer.
    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_req();
        for (int i = 0; i < N; i++) begin
            s_arvalid[i]           = pend[i];
            s_araddr[i*AW +: AW]   = paddr[i];
            s_arlen[i*8 +: 8]      = 8'(plen[i]);
        end
    endtask

    task automatic add_req(input int i, input logic [63:0] a, input int l);
        pend[i]  = 1'b1;
        paddr[i] = a;
        plen[i]  = l;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},   grant,     '0);
        chk({tag, "_arready"}, s_arready, '0);
        chk({tag, "_rvalid"},  s_rvalid,  '0);
        chk({tag, "_marvalid"}, m_arvalid, '0);
        chk({tag, "_maraddr"}, m_araddr,  '0);
        chk({tag, "_marlen"},  m_arlen,   '0);
        chk({tag, "_mrready"}, m_rready,  '0);
        chk({tag, "_err"},     err_len,   '0);
        chk({tag, "_rdata"},   s_rdata,   '0);
        chk({tag, "_rlast"},   s_rlast,   '0);
    endtask

    // One full burst for the model's predicted winner. nb_req>0 forces the
    // number of beats the slave sends; rst_beat>=0 resets after that beat.
    task automatic burst(input int nb_req, input bit bp, input int rst_beat);
        int w, t, len, nb, exp_err, sent, obs, errs, c, ar_wait;
        logic [N-1:0] oh;
        w = model_pick();
        if (w < 0) begin
            chk("no_requester", 0, 1);
            return;
        end
        oh = '0;
        oh[w] = 1'b1;
        len = plen[w];
        t = 0;
        while (grant == '0 && t < 6) begin
            nxt();
            t++;
        end
        chk("ar_latency", t, 1);
        chk("grant", grant, oh);
        ar_wait = bp ? 0 : $urandom_range(0, 2);
        c = 0;
        forever begin
            m_arready = (c >= ar_wait);
            #1;
            chk("m_arvalid", m_arvalid, 1);
            chk("m_araddr", m_araddr, paddr[w]);
            chk("m_arlen", m_arlen, plen[w]);
            chk("s_arready", s_arready, m_arready ? oh : '0);
            nxt();
            c++;
            if (c > ar_wait) break;
        end
        m_arready = 1'b0;
        pend[w] = 1'b0;
        apply_req();
        nb = (nb_req > 0) ? nb_req : len + 1;
        exp_err = ((nb != len + 1) ? 1 : 0) + ((nb > len + 1) ? 1 : 0);
        sent = 0; obs = 0; errs = 0; c = 0;
        while (sent < nb && c < 200) begin
            if (rst_beat >= 0 && sent == rst_beat) begin
                rst = 1'b1; m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = '1; m_arready = 1'b1;
                nxt();
                #1;
                chk_all_zero("rst_mid");
                rst = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b0;
                ptr = 0;
                return;
            end
            m_rvalid = bp ? 1'b1 : ($urandom_range(0, 9) < 7);
            if (bp) begin
                s_rready = '1;
                if (c >= 2 && c <= 4) s_rready[w] = 1'b0;
            end else begin
                s_rready = N'($urandom);
            end
            m_rdata = rand512();
            m_rlast = (sent == nb - 1);
            #1;
            chk("s_rvalid", s_rvalid, m_rvalid ? oh : '0);
            chk("m_rready", m_rready, s_rready[w]);
            chk("s_rdata", s_rdata, m_rdata);
            chk("s_rlast", s_rlast, m_rlast);
            if (err_len) errs++;
            if (m_rvalid && m_rready) begin
                sent++;
                if (s_rvalid[w] && s_rready[w]) obs++;
            end
            nxt();
            c++;
        end
        chk("data_budget", (c < 200), 1);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        chk("idle_grant", grant, '0);
        if (err_len) errs++;
        chk("beats", obs, nb);
        chk("err_pulses", errs, exp_err);
        ptr = (w + 1) % N;
    endtask

    // Requester x wins, then withdraws arvalid before the AR handshake.
    task automatic abort_req(input int x);
        logic [N-1:0] oh;
        oh = '0;
        oh[x] = 1'b1;
        add_req(x, 64'h0000_0000_DEAD_0000, 2);
        apply_req();
        nxt();
        chk("abort_grant", grant, oh);
        m_arready = 1'b0;
        #1;
        chk("abort_arvalid", m_arvalid, 1);
        nxt();
        pend[x] = 1'b0;
        apply_req();
        #1;
        chk("abort_arvalid_drop", m_arvalid, 0);
        nxt();
        chk("abort_idle", grant, '0);
    endtask

    initial begin
        int r, nbq;
        rst = 1'b1;
        ptr = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; paddr[i] = '0; plen[i] = 0;
        end
        apply_req();
        s_rready = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
        repeat (3) nxt();
        chk_all_zero("reset");
        rst = 1'b0;
        nxt();

        // Single request from column 2
        add_req(2, 64'h1000, 3);
        apply_req();
        burst(0, 1'b0, -1);

        // Round-robin: everyone requests with single-beat bursts
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) if (!pend[i]) add_req(i, {32'h0, $urandom}, 0);
            apply_req();
            burst(0, 1'b0, -1);
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        apply_req();
        nxt();

        // Backpressure on column 1
        add_req(1, 64'h0000_0000_0000_2000, 7);
        apply_req();
        burst(0, 1'b1, -1);

        // Length error: rlast arrives on the third beat of a four-beat burst
        add_req(3, 64'h0000_0000_0000_3000, 3);
        apply_req();
        burst(3, 1'b0, -1);

        // AR abort keeps the pointer, the next pick proves it
        abort_req(2);
        for (int i = 0; i < N; i++) add_req(i, {$urandom, $urandom}, 1);
        apply_req();
        burst(0, 1'b0, -1);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        apply_req();
        nxt();

        // Reset mid-burst on beat 2 of 8, then all request: pointer must be 0
        add_req(2, 64'h0000_0000_0000_4000, 7);
        apply_req();
        burst(0, 1'b0, 2);
        for (int i = 0; i < N; i++) add_req(i, {$urandom, $urandom}, 0);
        apply_req();
        burst(0, 1'b0, -1);

        // Randomized rounds
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    add_req(i, {$urandom, $urandom}, $urandom_range(0, 7));
            end
            if (model_pick() < 0) add_req($urandom_range(0, N - 1), {$urandom, $urandom}, $urandom_range(0, 7));
            apply_req();
            r = $urandom_range(0, 9);
            nbq = 0;
            if (r == 7 && plen[model_pick()] > 0) nbq = $urandom_range(1, plen[model_pick()]);
            else if (r >= 8) nbq = plen[model_pick()] + 2;
            burst(nbq, 1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
